// File: rtl/cpu_loader.sv
// rtl/cpu_loader.sv - byte-stream program/data loader driving the CPU memory write ports
// Decodes load/start/stop commands and pulses one IMEM or DMEM write per assembled word.
module cpu_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] CMD_IMEM  = 8'h01;
    localparam logic [7:0] CMD_DMEM  = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;
    localparam logic [7:0] CMD_STOP  = 8'h04;

    localparam logic [16:0] IMEM_LIMIT = 17'(IMEM_WORDS);
    localparam logic [16:0] DMEM_LIMIT = 17'(DMEM_WORDS);

    state_t      state_q, state_d;
    logic        dmem_q, dmem_d;
    logic [15:0] offset_q, offset_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [63:0] word_q, word_d;
    logic        cpu_en_q, cpu_en_d;
    logic [63:0] addr_i_q, addr_i_d;
    logic [31:0] wdata_i_q, wdata_i_d;
    logic [63:0] addr_d_q, addr_d_d;
    logic [63:0] wdata_d_q, wdata_d_d;

    logic        accept;
    logic        last_byte;
    logic [15:0] count_full;
    logic [16:0] span;
    logic [16:0] word_addr;
    logic [5:0]  lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dmem_q     <= 1'b0;
            offset_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            cpu_en_q   <= 1'b0;
            addr_i_q   <= '0;
            wdata_i_q  <= '0;
            addr_d_q   <= '0;
            wdata_d_q  <= '0;
        end else begin
            state_q    <= state_d;
            dmem_q     <= dmem_d;
            offset_q   <= offset_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            cpu_en_q   <= cpu_en_d;
            addr_i_q   <= addr_i_d;
            wdata_i_q  <= wdata_i_d;
            addr_d_q   <= addr_d_d;
            wdata_d_q  <= wdata_d_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dmem_d     = dmem_q;
        offset_d   = offset_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        cpu_en_d   = cpu_en_q;
        addr_i_d   = addr_i_q;
        wdata_i_d  = wdata_i_q;
        addr_d_d   = addr_d_q;
        wdata_d_d  = wdata_d_q;

        in_ready   = (state_q == IDLE) || (state_q == HDR) || (state_q == DATA);
        accept     = in_valid && in_ready;
        lane       = {byte_cnt_q, 3'b000};
        last_byte  = dmem_q ? (byte_cnt_q == 3'd7) : (byte_cnt_q == 3'd3);
        count_full = {in_data, count_q[7:0]};
        span       = {1'b0, offset_q} + {1'b0, count_full};
        word_addr  = {1'b0, offset_q} + {1'b0, idx_q};

        case (state_q)
            IDLE: begin
                if (accept) begin
                    byte_cnt_d = '0;
                    idx_d      = '0;
                    case (in_data)
                        CMD_IMEM, CMD_DMEM: begin
                            // Loading while the core runs would race its own fetches.
                            if (cpu_en_q) begin
                                state_d  = ERR;
                                cpu_en_d = 1'b0;
                            end else begin
                                state_d = HDR;
                                dmem_d  = (in_data == CMD_DMEM);
                            end
                        end
                        CMD_START: cpu_en_d = 1'b1;
                        CMD_STOP:  cpu_en_d = 1'b0;
                        default: begin
                            state_d  = ERR;
                            cpu_en_d = 1'b0;
                        end
                    endcase
                end
            end
            HDR: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    case (byte_cnt_q[1:0])
                        2'd0: offset_d[7:0]  = in_data;
                        2'd1: offset_d[15:8] = in_data;
                        2'd2: count_d[7:0]   = in_data;
                        default: begin
                            count_d    = count_full;
                            byte_cnt_d = '0;
                            if (span > (dmem_q ? DMEM_LIMIT : IMEM_LIMIT)) begin
                                state_d  = ERR;
                                cpu_en_d = 1'b0;
                            end else if (count_full == 16'd0) begin
                                state_d = IDLE;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    endcase
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[lane +: 8] = in_data;
                    byte_cnt_d        = byte_cnt_q + 3'd1;
                    if (last_byte) begin
                        // Port registers load here so they hold through and after the strobe.
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                        if (dmem_q) begin
                            addr_d_d  = {44'd0, word_addr, 3'b000};
                            wdata_d_d = word_d;
                        end else begin
                            addr_i_d  = {45'd0, word_addr, 2'b00};
                            wdata_i_d = word_d[31:0];
                        end
                    end
                end
            end
            WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == count_q) ? IDLE : DATA;
            end
            ERR: begin
                cpu_en_d = 1'b0;
            end
            default: begin
                state_d  = ERR;
                cpu_en_d = 1'b0;
            end
        endcase
    end

    assign wen_ext     = (state_q == WRITE) && !dmem_q;
    assign wen_ext_2   = (state_q == WRITE) && dmem_q;
    assign addr_ext    = addr_i_q;
    assign wdata_ext   = wdata_i_q;
    assign addr_ext_2  = addr_d_q;
    assign wdata_ext_2 = wdata_d_q;
    assign cpu_enable  = cpu_en_q;
    assign error       = (state_q == ERR);
    assign busy        = (state_q != IDLE) && (state_q != ERR);

endmodule

// File: tb/tb_cpu_loader.sv
// tb/tb_cpu_loader.sv - directed self-checking bench for cpu_loader
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    int tests = 0;
    int fails = 0;
    int bad_ready = 0;

    logic [63:0] lg_addr[$];
    logic [63:0] lg_data[$];
    bit          lg_dm[$];

    logic [7:0]  pay[24];
    logic [63:0] exp_word[3];
    logic [63:0] run_addr[2][3];
    logic [63:0] run_data[2][3];
    bit          ok;

    cpu_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Write logger plus in_ready/strobe consistency monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wen_ext) begin
            lg_addr.push_back(addr_ext);
            lg_data.push_back({32'd0, wdata_ext});
            lg_dm.push_back(1'b0);
        end
        if (wen_ext_2) begin
            lg_addr.push_back(addr_ext_2);
            lg_data.push_back(wdata_ext_2);
            lg_dm.push_back(1'b1);
        end
        if ((wen_ext || wen_ext_2) && in_ready) bad_ready++;
        if (wen_ext && wen_ext_2) bad_ready++;
        if (!in_ready && !wen_ext && !wen_ext_2 && !error && !rst) bad_ready++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps, output bit accepted);
        accepted = 1'b0;
        repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) in_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b, input int gaps);
        bit acc;
        send_byte(b, gaps, acc);
        chk("byte_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lg_addr.delete();
        lg_data.delete();
        lg_dm.delete();
    endtask

    task automatic dmem3(input bit rnd);
        put(8'h02, 0); put(8'h05, 0); put(8'h00, 0); put(8'h03, 0); put(8'h00, 0);
        for (int i = 0; i < 24; i++) put(pay[i], rnd ? int'($urandom_range(0, 3)) : 0);
        settle();
    endtask

    initial begin
        for (int i = 0; i < 24; i++) pay[i] = 8'(8'h31 + i * 13);
        for (int w = 0; w < 3; w++) begin
            exp_word[w] = '0;
            for (int b = 0; b < 8; b++) exp_word[w] = exp_word[w] | (64'(pay[w*8+b]) << (8*b));
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        chk("rst_wen_ext", {63'd0, wen_ext}, 64'd0);
        chk("rst_wen_ext_2", {63'd0, wen_ext_2}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // IMEM load, offset 2 count 2
        put(8'h01, 0); put(8'h02, 0); put(8'h00, 0); put(8'h02, 0); put(8'h00, 0);
        put(8'h13, 0); put(8'h00, 0); put(8'h00, 0); put(8'h00, 0);
        put(8'h93, 0); put(8'h00, 0); put(8'h10, 0); put(8'h00, 0);
        settle();
        chk("imem_nwrites", 64'(lg_addr.size()), 64'd2);
        if (lg_addr.size() == 2) begin
            chk("imem_kind0", {63'd0, lg_dm[0]}, 64'd0);
            chk("imem_addr0", lg_addr[0], 64'h8);
            chk("imem_data0", lg_data[0], 64'h00000013);
            chk("imem_kind1", {63'd0, lg_dm[1]}, 64'd0);
            chk("imem_addr1", lg_addr[1], 64'hC);
            chk("imem_data1", lg_data[1], 64'h00100093);
        end
        chk("imem_busy_after", {63'd0, busy}, 64'd0);
        chk("imem_ready_after", {63'd0, in_ready}, 64'd1);
        chk("imem_addr_hold", addr_ext, 64'hC);

        // DMEM load, offset 0 count 1
        lg_addr.delete(); lg_data.delete(); lg_dm.delete();
        put(8'h02, 0); put(8'h00, 0); put(8'h00, 0); put(8'h01, 0); put(8'h00, 0);
        put(8'h88, 0); put(8'h77, 0); put(8'h66, 0); put(8'h55, 0);
        put(8'h44, 0); put(8'h33, 0); put(8'h22, 0); put(8'h11, 0);
        settle();
        chk("dmem_nwrites", 64'(lg_addr.size()), 64'd1);
        if (lg_addr.size() == 1) begin
            chk("dmem_kind", {63'd0, lg_dm[0]}, 64'd1);
            chk("dmem_addr", lg_addr[0], 64'h0);
            chk("dmem_data", lg_data[0], 64'h1122334455667788);
        end

        // count 0: header only, no writes, back to IDLE
        lg_addr.delete(); lg_data.delete(); lg_dm.delete();
        put(8'h01, 0); put(8'h10, 0); put(8'h00, 0); put(8'h00, 0); put(8'h00, 0);
        settle();
        chk("cnt0_nwrites", 64'(lg_addr.size()), 64'd0);
        chk("cnt0_busy", {63'd0, busy}, 64'd0);

        // Exactly fills IMEM: offset 511 count 1 is legal
        put(8'h01, 0); put(8'hFF, 0); put(8'h01, 0); put(8'h01, 0); put(8'h00, 0);
        put(8'hEF, 0); put(8'hBE, 0); put(8'hAD, 0); put(8'hDE, 0);
        settle();
        chk("edge_nwrites", 64'(lg_addr.size()), 64'd1);
        if (lg_addr.size() == 1) begin
            chk("edge_addr", lg_addr[0], 64'h7FC);
            chk("edge_data", lg_data[0], 64'hDEADBEEF);
        end
        chk("edge_error", {63'd0, error}, 64'd0);

        // One word past IMEM: offset 511 count 2 -> ERR
        lg_addr.delete(); lg_data.delete(); lg_dm.delete();
        put(8'h01, 0); put(8'hFF, 0); put(8'h01, 0); put(8'h02, 0); put(8'h00, 0);
        settle();
        chk("range_error", {63'd0, error}, 64'd1);
        chk("range_in_ready", {63'd0, in_ready}, 64'd0);
        chk("range_busy", {63'd0, busy}, 64'd0);
        send_byte(8'h13, 0, ok);
        chk("range_blocked", {63'd0, ok}, 64'd0);
        settle();
        chk("range_nwrites", 64'(lg_addr.size()), 64'd0);

        // START / illegal load while running / STOP
        do_reset();
        chk("rst2_error", {63'd0, error}, 64'd0);
        put(8'h03, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_enable", {63'd0, cpu_enable}, 64'd1);
        put(8'h03, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_repeat", {63'd0, cpu_enable}, 64'd1);
        put(8'h01, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("load_running_error", {63'd0, error}, 64'd1);
        chk("load_running_cpu_off", {63'd0, cpu_enable}, 64'd0);
        do_reset();
        chk("rst3_error", {63'd0, error}, 64'd0);
        chk("rst3_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst3_cpu_enable", {63'd0, cpu_enable}, 64'd0);
        put(8'h03, 0);
        @(negedge clk);
        chk("start2_enable", {63'd0, cpu_enable}, 64'd1);
        put(8'h04, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stop_enable", {63'd0, cpu_enable}, 64'd0);
        put(8'h7E, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bad_cmd_error", {63'd0, error}, 64'd1);

        // 3-word DMEM load, back-to-back then with random in_valid gaps
        for (int r = 0; r < 2; r++) begin
            do_reset();
            dmem3(r == 1);
            chk($sformatf("dm3_nwrites_%0d", r), 64'(lg_addr.size()), 64'd3);
            for (int w = 0; w < 3; w++) begin
                run_addr[r][w] = (lg_addr.size() > w) ? lg_addr[w] : 64'hX;
                run_data[r][w] = (lg_data.size() > w) ? lg_data[w] : 64'hX;
                chk($sformatf("dm3_addr_%0d_%0d", r, w), run_addr[r][w], 64'(40 + 8 * w));
                chk($sformatf("dm3_data_%0d_%0d", r, w), run_data[r][w], exp_word[w]);
            end
        end

        // Reset mid-word: no partial write, outputs back to reset values
        do_reset();
        put(8'h02, 0); put(8'h00, 0); put(8'h00, 0); put(8'h01, 0); put(8'h00, 0);
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0);
        do_reset();
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_addr_ext_2", addr_ext_2, 64'd0);
        chk("midrst_wdata_ext_2", wdata_ext_2, 64'd0);
        chk("midrst_addr_ext", addr_ext, 64'd0);
        repeat (12) @(negedge clk);
        chk("midrst_nwrites", 64'(lg_addr.size()), 64'd0);

        chk("ready_strobe_consistency", 64'(bad_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
